spi_master_engine: RTL

- Parametrised SPI controller and successor to the current fixed-width controller.
- Generates SCK internally from a programmable divider and supports all four CPOL/CPHA modes per transfer.
- Supports MSB- or LSB-first ordering and drives NUM_CS one-hot-low chip selects.
- Sits between a register or bus front-end (valid/ready command side) and the SPI pins.

---
 rtl/spi_master_engine.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/spi_master_engine.sv
// spi_master_engine
//   SPI master with an internal SCK divider, per-transfer CPOL/CPHA, MSB- or
//   LSB-first ordering and NUM_CS one-hot-low chip selects. A command is taken
//   on tx_valid & tx_ready. Mode, divider and chip select are captured with the
//   data word at that moment.
//
// Ports
//   clk, rst            system clock, synchronous active-high reset
//   cpol, cpha          SPI mode, captured at accept
//   lsb_first           1: bit 0 goes out first and the first bit in lands at bit 0
//   clk_div             SCK half-period minus 1, in clk cycles
//   cs_sel              chip-select index. Values >= NUM_CS assert no select.
//   tx_valid/tx_ready   command handshake; tx_data is the word to shift out
//   rx_valid/rx_data    one-cycle completion pulse with the captured word
//   busy                transfer in progress
//   sck, mosi, miso     SPI pins (miso already synchronised)
//   cs_n                active-low chip selects
module spi_master_engine #(
    parameter  int DATA_WIDTH = 8,
    parameter  int NUM_CS     = 4,
    parameter  int DIV_WIDTH  = 8,
    localparam int CS_W       = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cpol,
    input  logic                  cpha,
    input  logic                  lsb_first,
    input  logic [DIV_WIDTH-1:0]  clk_div,
    input  logic [CS_W-1:0]       cs_sel,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  rx_valid,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  busy,
    output logic                  sck,
    output logic                  mosi,
    input  logic                  miso,
    output logic [NUM_CS-1:0]     cs_n
);

    localparam int ECW = $clog2(2 * DATA_WIDTH + 1);
    localparam logic [ECW-1:0] LAST_EDGE = ECW'(2 * DATA_WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        XFER,
        HOLD
    } state_t;

    state_t                state_q, state_d;
    logic [DIV_WIDTH-1:0]  div_cnt_q, div_cnt_d;
    logic [DIV_WIDTH-1:0]  div_q, div_d;
    logic [ECW-1:0]        edge_cnt_q, edge_cnt_d;
    logic [ECW-1:0]        edge_k;
    logic                  cpol_q, cpol_d;
    logic                  cpha_q, cpha_d;
    logic                  lsb_q, lsb_d;
    logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;
    logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_d;
    logic                  sck_q, sck_d;
    logic                  mosi_q, mosi_d;
    logic [NUM_CS-1:0]     cs_n_q, cs_n_d;
    logic                  busy_q, busy_d;
    logic                  tx_ready_q, tx_ready_d;
    logic                  rx_valid_q, rx_valid_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;

    function automatic logic head_bit(input logic [DATA_WIDTH-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DATA_WIDTH-1];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] shift_out(input logic [DATA_WIDTH-1:0] w,
                                                        input logic lsb);
        return lsb ? (w >> 1) : (w << 1);
    endfunction

    // Out-of-range indices match no bit, so every select stays high.
    function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] sel);
        logic [NUM_CS-1:0] v;
        v = '1;
        for (int unsigned i = 0; i < NUM_CS; i++) begin
            if (32'(sel) == i) begin
                v[i] = 1'b0;
            end
        end
        return v;
    endfunction

    always_comb begin
        state_d    = state_q;
        div_cnt_d  = div_cnt_q;
        div_d      = div_q;
        edge_cnt_d = edge_cnt_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        lsb_d      = lsb_q;
        tx_sr_d    = tx_sr_q;
        rx_sr_d    = rx_sr_q;
        sck_d      = sck_q;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;
        busy_d     = busy_q;
        tx_ready_d = tx_ready_q;
        rx_valid_d = 1'b0;
        rx_data_d  = rx_data_q;
        edge_k     = edge_cnt_q + 1'b1;

        case (state_q)
            IDLE: begin
                tx_ready_d = 1'b1;
                sck_d      = cpol_q;
                if (tx_valid && tx_ready_q) begin
                    tx_ready_d = 1'b0;
                    cpol_d     = cpol;
                    cpha_d     = cpha;
                    lsb_d      = lsb_first;
                    div_d      = clk_div;
                    div_cnt_d  = clk_div;
                    edge_cnt_d = '0;
                    sck_d      = cpol;
                    busy_d     = 1'b1;
                    cs_n_d     = cs_decode(cs_sel);
                    rx_sr_d    = '0;
                    // CPHA=0 needs the first bit on the wire before the first edge;
                    // CPHA=1 leaves mosi untouched until the leading edge.
                    if (!cpha) begin
                        mosi_d  = head_bit(tx_data, lsb_first);
                        tx_sr_d = shift_out(tx_data, lsb_first);
                    end else begin
                        tx_sr_d = tx_data;
                    end
                    state_d = SETUP;
                end
            end

            SETUP, XFER: begin
                if (div_cnt_q != '0) begin
                    div_cnt_d = div_cnt_q - 1'b1;
                end else begin
                    div_cnt_d  = div_q;
                    edge_cnt_d = edge_k;
                    sck_d      = ~sck_q;
                    // Odd edges are leading. Sampling happens on leading edges for
                    // CPHA=0 and on trailing edges for CPHA=1; the other edge drives.
                    if (edge_k[0] != cpha_q) begin
                        rx_sr_d = lsb_q ? {miso, rx_sr_q[DATA_WIDTH-1:1]}
                                        : {rx_sr_q[DATA_WIDTH-2:0], miso};
                    end else if (edge_k != LAST_EDGE) begin
                        mosi_d  = head_bit(tx_sr_q, lsb_q);
                        tx_sr_d = shift_out(tx_sr_q, lsb_q);
                    end
                    state_d = (edge_k == LAST_EDGE) ? HOLD : XFER;
                end
            end

            HOLD: begin
                if (div_cnt_q != '0) begin
                    div_cnt_d = div_cnt_q - 1'b1;
                end else begin
                    state_d    = IDLE;
                    cs_n_d     = '1;
                    busy_d     = 1'b0;
                    rx_valid_d = 1'b1;
                    rx_data_d  = rx_sr_q;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            div_cnt_q  <= '0;
            div_q      <= '0;
            edge_cnt_q <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            lsb_q      <= 1'b0;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            sck_q      <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= '1;
            busy_q     <= 1'b0;
            tx_ready_q <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            div_cnt_q  <= div_cnt_d;
            div_q      <= div_d;
            edge_cnt_q <= edge_cnt_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            lsb_q      <= lsb_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            sck_q      <= sck_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
            busy_q     <= busy_d;
            tx_ready_q <= tx_ready_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
        end
    end

    assign tx_ready = tx_ready_q;
    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign busy     = busy_q;
    assign sck      = sck_q;
    assign mosi     = mosi_q;
    assign cs_n     = cs_n_q;

endmodule
